// File: rtl/ascon_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_permutation_ctrl
//   Iterative Ascon-p permutation engine: one round per clock, 0..16 rounds
//   per request, valid/ready handshakes on both sides.
//
//   Ports
//     clk_i         rising-edge clock
//     rst_ni        synchronous active-low reset
//     valid_i       request valid (qualifies state_i, rnd_i)
//     ready_o       engine idle, request can be accepted
//     state_i       320-bit input state (5 x 64-bit words)
//     rnd_i         round count, values above MAX_RND clamp to MAX_RND
//     valid_o       state_o holds a finished result
//     ready_i       consumer takes the result
//     state_o       working register (also visible between rounds)
//     busy_o        rounds in progress
//     perm_count_o  completed handoffs, 32-bit wrapping
//                   (only with `define ASCON_PERM_PERF_CNT_EN)
//
//   Round constants follow the 16-entry table c0..c15; an r-round
//   permutation uses c[16-r] .. c[15].
// ---------------------------------------------------------------------------
package ascon_pkg;
    typedef logic [4:0][63:0] ascon_state_t;
endpackage

// Ascon linear diffusion layer: x ^= rotr(x, a) ^ rotr(x, b) per word.
module linear_diffusion_layer
    import ascon_pkg::*;
(
    input  ascon_state_t x_i,
    output ascon_state_t x_o
);
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign x_o[0] = x_i[0] ^ rotr(x_i[0], 19) ^ rotr(x_i[0], 28);
    assign x_o[1] = x_i[1] ^ rotr(x_i[1], 61) ^ rotr(x_i[1], 39);
    assign x_o[2] = x_i[2] ^ rotr(x_i[2], 1)  ^ rotr(x_i[2], 6);
    assign x_o[3] = x_i[3] ^ rotr(x_i[3], 10) ^ rotr(x_i[3], 17);
    assign x_o[4] = x_i[4] ^ rotr(x_i[4], 7)  ^ rotr(x_i[4], 41);
endmodule

module ascon_permutation_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned MAX_RND = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  ascon_state_t state_i,
    input  logic [4:0]   rnd_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
`ifdef ASCON_PERM_PERF_CNT_EN
    ,
    output logic [31:0]  perm_count_o
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    ascon_state_t work_q, work_d;
    logic [4:0]   rnd_q, rnd_d;
    logic [4:0]   idx_q, idx_d;

    ascon_state_t sbox_out, round_out;
    ascon_state_t x;
    logic [4:0][63:0] t;
    logic [3:0]   rc_idx;
    logic [7:0]   rc;

    function automatic logic [7:0] rc_lut(input logic [3:0] k);
        logic [7:0] c;
        case (k)
            4'd0:  c = 8'h3c;
            4'd1:  c = 8'h2d;
            4'd2:  c = 8'h1e;
            4'd3:  c = 8'h0f;
            4'd4:  c = 8'hf0;
            4'd5:  c = 8'he1;
            4'd6:  c = 8'hd2;
            4'd7:  c = 8'hc3;
            4'd8:  c = 8'hb4;
            4'd9:  c = 8'ha5;
            4'd10: c = 8'h96;
            4'd11: c = 8'h87;
            4'd12: c = 8'h78;
            4'd13: c = 8'h69;
            4'd14: c = 8'h5a;
            default: c = 8'h4b;
        endcase
        return c;
    endfunction

    // While RUN, idx_q < rnd_q <= 16, so 16 - rnd + idx always lies in 0..15.
    assign rc_idx = 4'(5'(MAX_RND) - rnd_q + idx_q);
    assign rc     = rc_lut(rc_idx);

    // Constant addition followed by the bitsliced 5-bit S-box.
    always_comb begin
        x = work_q;
        x[2][7:0] = x[2][7:0] ^ rc;
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t[0] = ~x[0] & x[1];
        t[1] = ~x[1] & x[2];
        t[2] = ~x[2] & x[3];
        t[3] = ~x[3] & x[4];
        t[4] = ~x[4] & x[0];
        x[0] = x[0] ^ t[1];
        x[1] = x[1] ^ t[2];
        x[2] = x[2] ^ t[3];
        x[3] = x[3] ^ t[4];
        x[4] = x[4] ^ t[0];
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        sbox_out = x;
    end

    linear_diffusion_layer u_pl (
        .x_i (sbox_out),
        .x_o (round_out)
    );

`ifdef ASCON_PERM_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    assign perm_count_o = cnt_q;
`endif

    always_comb begin
        fsm_d  = fsm_q;
        work_d = work_q;
        rnd_d  = rnd_q;
        idx_d  = idx_q;
`ifdef ASCON_PERM_PERF_CNT_EN
        cnt_d  = cnt_q;
`endif
        unique case (fsm_q)
            IDLE: begin
                if (valid_i) begin
                    work_d = state_i;
                    rnd_d  = (rnd_i > 5'(MAX_RND)) ? 5'(MAX_RND) : rnd_i;
                    idx_d  = '0;
                    fsm_d  = (rnd_i == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                work_d = round_out;
                idx_d  = idx_q + 5'd1;
                if (idx_q == rnd_q - 5'd1) fsm_d = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    fsm_d = IDLE;
`ifdef ASCON_PERM_PERF_CNT_EN
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q  <= IDLE;
            work_q <= '0;
            rnd_q  <= '0;
            idx_q  <= '0;
`ifdef ASCON_PERM_PERF_CNT_EN
            cnt_q  <= '0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            work_q <= work_d;
            rnd_q  <= rnd_d;
            idx_q  <= idx_d;
`ifdef ASCON_PERM_PERF_CNT_EN
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign busy_o  = (fsm_q == RUN);
    assign valid_o = (fsm_q == DONE);
    assign state_o = work_q;
endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_permutation_ctrl
//   Directed bench for ascon_permutation_ctrl. Expected results come from
//   hand-computed constants and from a table-driven Ascon-p reference
//   (column-wise S-box lookup). Counter checks are compiled in when
//   ASCON_PERM_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ascon_permutation_ctrl;
    import ascon_pkg::*;

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    ascon_state_t state_i;
    logic [4:0]   rnd_i;
    logic         valid_o;
    logic         ready_i;
    ascon_state_t state_o;
    logic         busy_o;
`ifdef ASCON_PERM_PERF_CNT_EN
    logic [31:0]  perm_count_o;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ascon_permutation_ctrl #(.MAX_RND(16)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .state_i (state_i),
        .rnd_i   (rnd_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .state_o (state_o),
        .busy_o  (busy_o)
`ifdef ASCON_PERM_PERF_CNT_EN
        ,
        .perm_count_o (perm_count_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [4:0] sbox_ref(input logic [4:0] v);
        logic [4:0] r;
        case (v)
            5'd0:  r = 5'h04; 5'd1:  r = 5'h0b; 5'd2:  r = 5'h1f; 5'd3:  r = 5'h14;
            5'd4:  r = 5'h1a; 5'd5:  r = 5'h15; 5'd6:  r = 5'h09; 5'd7:  r = 5'h02;
            5'd8:  r = 5'h1b; 5'd9:  r = 5'h05; 5'd10: r = 5'h08; 5'd11: r = 5'h12;
            5'd12: r = 5'h1d; 5'd13: r = 5'h03; 5'd14: r = 5'h06; 5'd15: r = 5'h1c;
            5'd16: r = 5'h1e; 5'd17: r = 5'h13; 5'd18: r = 5'h07; 5'd19: r = 5'h0e;
            5'd20: r = 5'h00; 5'd21: r = 5'h0d; 5'd22: r = 5'h11; 5'd23: r = 5'h18;
            5'd24: r = 5'h10; 5'd25: r = 5'h0c; 5'd26: r = 5'h01; 5'd27: r = 5'h19;
            5'd28: r = 5'h16; 5'd29: r = 5'h0a; 5'd30: r = 5'h0f; default: r = 5'h17;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic ascon_state_t model_p(input ascon_state_t s_in, input int rnd);
        ascon_state_t s;
        logic [4:0]   col;
        logic [4:0]   o;
        int           n;
        int           j;
        logic [7:0]   c;
        s = s_in;
        n = (rnd > 16) ? 16 : rnd;
        for (int i = 0; i < n; i++) begin
            j = 16 - n + i;
            c = 8'((((3 - j) & 15) << 4) | ((j + 12) & 15));
            s[2] = s[2] ^ {56'd0, c};
            for (int b = 0; b < 64; b++) begin
                col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
                o = sbox_ref(col);
                s[0][b] = o[4]; s[1][b] = o[3]; s[2][b] = o[2];
                s[3][b] = o[1]; s[4][b] = o[0];
            end
            s[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
            s[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
            s[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
            s[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
            s[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
        end
        return s;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request, measure latency, hold the result for 5 cycles with
    // ready_i low, then hand it off.
    task automatic run_job(input string tag, input ascon_state_t st, input logic [4:0] r,
                           input int exp_lat, input ascon_state_t exp_st);
        int lat;
        chk({tag, " ready_before"}, 320'(ready_o), 320'd1);
        state_i = st;
        rnd_i   = r;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        state_i = ~st;
        rnd_i   = 5'd3;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 320'(lat), 320'(exp_lat));
        chk({tag, " result"}, state_o, exp_st);
        for (int k = 0; k < 5; k++) tick();
        chk({tag, " hold_state"}, state_o, exp_st);
        chk({tag, " hold_flags"}, {317'd0, valid_o, busy_o, ready_o}, {317'd0, 3'b100});
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk({tag, " after_handoff"}, {318'd0, valid_o, ready_o}, {318'd0, 2'b01});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ascon_state_t a;
        ascon_state_t b;
        ascon_state_t z;
        int lat;

        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        state_i = '0;
        rnd_i   = '0;
        z       = '0;
        tick();
        tick();
        chk("reset ready_o", 320'(ready_o), 320'd1);
        chk("reset valid_o", 320'(valid_o), 320'd0);
        chk("reset busy_o",  320'(busy_o),  320'd0);
        chk("reset state_o", state_o, 320'd0);
        rst_ni = 1'b1;
        tick();

        // One round of an all-zero state.
        run_job("zero_r1", z, 5'd1, 1, model_p(z, 1));
        chk("zero_r1 word2", 320'(state_o[2]), 320'(64'h53FFFFFFFFFFFF90));
        chk("zero_r1 word4", 320'(state_o[4]), 320'd0);

        // Zero rounds passes the input straight through.
        a = rand_state();
        run_job("r0_pass", a, 5'd0, 0, a);

        a = rand_state();
        run_job("r6", a, 5'd6, 6, model_p(a, 6));
        a = rand_state();
        run_job("r8", a, 5'd8, 8, model_p(a, 8));
        a = rand_state();
        run_job("r12", a, 5'd12, 12, model_p(a, 12));
        a = rand_state();
        run_job("r16", a, 5'd16, 16, model_p(a, 16));
        a = rand_state();
        run_job("r31_clamp", a, 5'd31, 16, model_p(a, 16));

        // Reset during round 5 of 12 abandons the job.
        a = rand_state();
        state_i = a;
        rnd_i   = 5'd12;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("abort busy_mid", 320'(busy_o), 320'd1);
        chk("abort intermediate", state_o, model_p(a, 12) == state_o ? 320'd0 : state_o);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("abort flags", {317'd0, valid_o, busy_o, ready_o}, {317'd0, 3'b001});
        chk("abort state_o", state_o, 320'd0);
        tick();
        chk("abort no_valid", 320'(valid_o), 320'd0);
        a = rand_state();
        run_job("post_abort_r12", a, 5'd12, 12, model_p(a, 12));

        // valid_i and ready_i held high through RUN: no second accept,
        // inputs sampled only at accept.
        a = rand_state();
        b = rand_state();
        ready_i = 1'b1;
        state_i = a;
        rnd_i   = 5'd8;
        valid_i = 1'b1;
        tick();
        state_i = b;
        rnd_i   = 5'd3;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("hold_valid latency", 320'(lat), 320'd8);
        chk("hold_valid result", state_o, model_p(a, 8));
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("hold_valid idle", 320'(ready_o), 320'd1);

`ifdef ASCON_PERM_PERF_CNT_EN
        chk("perf count_pre", 320'(perm_count_o), 320'd2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("perf count_reset", 320'(perm_count_o), 320'd0);
        for (int k = 0; k < 3; k++) begin
            a = rand_state();
            run_job("perf_job", a, 5'd2, 2, model_p(a, 2));
        end
        chk("perf count_3", 320'(perm_count_o), 320'd3);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ascon_permutation_ctrl.md
ASCON_PERMUTATION_CTRL -- requirements
Module: ascon_permutation_ctrl

Interface
REQ-001 Parameter: MAX_RND, 16, largest accepted round count; SP 800-232 constant table c0..c15.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  synchronous, active-low reset.
REQ-004 valid_i  input  1  request valid; state_i and rnd_i are qualified by it.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 state_i  input  ascon_state_t (5x64)  permutation input state.
REQ-007 rnd_i  input  5  number of rounds, 0..16.
REQ-008 valid_o  output  1  state_o holds a finished result.
REQ-009 ready_i  input  1  consumer accepts the result.
REQ-010 state_o  output  ascon_state_t  permutation result.
REQ-011 busy_o  output  1  high while rounds are in progress.

Function
REQ-012 FSM SHALL have three states: IDLE, RUN, DONE; ready_o=1 only in IDLE, busy_o=1 only in RUN, valid_o=1 only in DONE.
REQ-013 Accept SHALL occur when valid_i && ready_o; on that edge, capture state_i into the working register, load the round count (rnd_i>16 clamps to 16), and clear the round index.
REQ-014 Accept transition SHALL be IDLE->RUN when the count is nonzero, and IDLE->DONE with the state unchanged when rnd_i==0.
REQ-015 Each RUN cycle SHALL apply one round to the working register: constant addition, then bitsliced 5-bit S-box, then a linear_diffusion_layer instance.
REQ-016 Constant addition SHALL XOR c[16-rnd+i] into bits 7:0 of word 2 in round i (i=0..rnd-1).
REQ-017 The RUN->DONE transition SHALL take place on the edge that applies the last round; valid_o SHALL rise exactly rnd cycles after the accept edge.
REQ-018 In DONE, state_o and valid_o SHALL hold stable until ready_i; valid_o && ready_i SHALL return the FSM to IDLE on that edge.
REQ-019 A request SHALL NOT be accepted in the same cycle as a DONE handoff, because ready_o=0 in DONE.
REQ-020 valid_i in RUN/DONE SHALL be ignored; inputs SHALL be sampled only at accept.
REQ-021 ready_i outside DONE SHALL have no effect.
REQ-022 state_o SHALL equal the working register in all states, including intermediate rounds while busy_o=1.

Reset
REQ-023 When rst_ni=0 at a clock edge: FSM=IDLE, working register=0, round index=0; result: ready_o=1, valid_o=0, busy_o=0, state_o=0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no output handshake; the first accept after release SHALL behave as from power-up.

Configuration
REQ-025 Macro ASCON_PERM_PERF_CNT_EN: when defined, add output perm_count_o (32 bits).
REQ-026 perm_count_o SHALL increment on each DONE handoff (valid_o && ready_i), wrap 0xFFFFFFFF->0, and reset to 0.
REQ-027 Without ASCON_PERM_PERF_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then hold rst_ni=0 for 2 cycles -> ready_o=1, valid_o=0, busy_o=0, state_o=320'h0.
REQ-029 All-zero state_i with rnd_i=1 -> valid_o after 1 cycle; word2=64'h53FFFFFFFFFFFF90, word4=64'h0.
REQ-030 Random state_i with rnd_i=0 -> valid_o the next cycle; state_o==state_i bit-exact.
REQ-031 Random state_i with rnd_i in {6,8,12,16,31} -> latency 6/8/12/16/16 cycles; state_o matches the software Ascon-p model; hold ready_i=0 for 5 cycles -> state_o stable.
REQ-032 Assert rst_ni=0 at round 5 of 12, then issue a new request -> no valid_o from the aborted job; the new result is correct.
REQ-033 With ASCON_PERM_PERF_CNT_EN, 3 back-to-back jobs -> perm_count_o=3; valid_i held high in RUN -> no extra accept.
